// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4:1 TDM link, rebuilds channels A..D from one slot-aligned stream
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   i_din               sample for the current slot (WIDTH bits)
//   i_din_valid         a beat is taken on this edge
//   i_frame_sync        with i_din_valid: this beat is slot 0
//   o_a, o_b            regenerated select, {o_a,o_b} = slot of the next beat
//   o_A..o_D            published channels for slots 0..3
//   o_frame_valid       1-cycle pulse, o_A..o_D just updated
//   o_sync_err          1-cycle pulse, frame_sync arrived mid-frame
//   o_frame_cnt         8-bit published-frame counter (only with TDM_DEMUX4_FCNT_EN)
//   o_locked            high while in LOCK
module tdm_demux4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_din_valid,
   input  logic             i_frame_sync,
   output logic             o_a,
   output logic             o_b,
   output logic [WIDTH-1:0] o_A,
   output logic [WIDTH-1:0] o_B,
   output logic [WIDTH-1:0] o_C,
   output logic [WIDTH-1:0] o_D,
   output logic             o_frame_valid,
   output logic             o_sync_err,
`ifdef TDM_DEMUX4_FCNT_EN
   output logic [7:0]       o_frame_cnt,
`endif
   output logic             o_locked
);
   typedef enum logic {HUNT, LOCK} state_t;
   state_t           r_state, w_state_nx;
   logic [1:0]       r_slot, w_slot_nx, w_idx;
   logic [WIDTH-1:0] r_sh [3];
   logic [WIDTH-1:0] r_A, r_B, r_C, r_D;
   logic             r_fv, r_serr;
   logic             w_sync, w_wr, w_pub, w_err;
`ifdef TDM_DEMUX4_FCNT_EN
   logic [7:0]       r_fcnt;
   assign o_frame_cnt = r_fcnt;
`endif
   always_ff @(posedge clk)
      if (rst) r_state <= HUNT;
      else     r_state <= w_state_nx;
   // A sync beat always restarts the frame at slot 0; in HUNT only sync beats are taken.
   // Slot 3 is never shadowed: its sample goes straight to o_D at publish time.
   always_comb begin
      w_sync     = i_din_valid && i_frame_sync;
      w_wr       = w_sync || (i_din_valid && r_state == LOCK);
      w_pub      = i_din_valid && !i_frame_sync && r_state == LOCK && r_slot == 2'd3;
      w_err      = w_sync && r_state == LOCK && r_slot != 2'd0;
      w_idx      = w_sync ? 2'd0 : r_slot;
      w_state_nx = w_sync ? LOCK : r_state;
      w_slot_nx  = w_sync ? 2'd1 : (w_wr ? r_slot + 2'd1 : r_slot);
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_slot <= '0;
         r_sh   <= '{default: '0};
         r_A    <= '0;
         r_B    <= '0;
         r_C    <= '0;
         r_D    <= '0;
         r_fv   <= 1'b0;
         r_serr <= 1'b0;
`ifdef TDM_DEMUX4_FCNT_EN
         r_fcnt <= '0;
`endif
      end else begin
         r_slot <= w_slot_nx;
         r_fv   <= w_pub;
         r_serr <= w_err;
         if (w_wr && w_idx != 2'd3) r_sh[w_idx] <= i_din;
         if (w_pub) {r_A, r_B, r_C, r_D} <= {r_sh[0], r_sh[1], r_sh[2], i_din};
`ifdef TDM_DEMUX4_FCNT_EN
         if (w_pub) r_fcnt <= r_fcnt + 8'd1;
`endif
      end
   assign o_a           = r_slot[1];
   assign o_b           = r_slot[0];
   assign o_A           = r_A;
   assign o_B           = r_B;
   assign o_C           = r_C;
   assign o_D           = r_D;
   assign o_frame_valid = r_fv;
   assign o_sync_err    = r_serr;
   assign o_locked      = r_state == LOCK;
endmodule
